// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: sequencer and round-robin arbiter in front of clock_divisor.
//
// Each divisor change stops the divider on a clean phase boundary with div_clk
// parked at PARK_LEVEL. It then loads the new divisor, checks that the divider
// took it, and resumes if run_req is still high. Two requesters share the
// divisor; a tie goes to the requester that was not granted last.
//
// Optional feature (macro CLK_DIV_CTRL_SKIP_SAME_EN): in RUN, a granted request
// whose divisor already equals div_cur is acked without stopping the divider.
//
// Ports:
//   clk_i       system clock, shared with clock_divisor
//   rst         synchronous active-high reset
//   run_req     level, divided clock requested running
//   req[1:0]    level, requester n wants a divisor change (held until ack[n])
//   req_div0/1  divisor requested by requester 0/1
//   ack[1:0]    one-cycle pulse, requester n's divisor applied
//   div_clk_en  clock_divisor clk_en
//   div_set     clock_divisor set_clk_div
//   div_cur     clock_divisor clk_div (readback)
//   div_clk     clock_divisor clk_o
//   running     equals div_clk_en
//   busy        high while draining, loading or verifying
//   err         sticky verify mismatch, cleared only by rst

module clock_div_ctrl #(
  parameter int unsigned DIV_W      = 4,
  parameter logic        PARK_LEVEL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             run_req,
  input  logic [1:0]       req,
  input  logic [DIV_W-1:0] req_div0,
  input  logic [DIV_W-1:0] req_div1,
  output logic [1:0]       ack,
  output logic             div_clk_en,
  output logic [DIV_W-1:0] div_set,
  input  logic [DIV_W-1:0] div_cur,
  input  logic             div_clk,
  output logic             running,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {StOff, StRun, StDrain, StLoad, StVerify} state_e;

  state_e           state_q;
  logic             en_q;
  logic [1:0]       ack_q;
  logic [DIV_W-1:0] set_q;
  logic [DIV_W-1:0] ph_q;
  logic             last_q;
  logic             vsec_q;
  logic             err_q;

  logic [1:0]       req_eff;
  logic             any_req;
  logic             win;
  logic [DIV_W-1:0] win_div;
  logic             ph_wrap;

  // A requester sees its ack one cycle late, so its still-high req must not
  // start a second pass during the ack cycle.
  assign req_eff = req & ~ack_q;
  assign any_req = |req_eff;
  assign win     = (req_eff == 2'b11) ? ~last_q : req_eff[1];
  assign win_div = win ? req_div1 : req_div0;
  // Divider toggles on this edge when enabled.
  assign ph_wrap = (ph_q == div_cur);

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= StOff;
      en_q    <= 1'b0;
      ack_q   <= 2'b00;
      set_q   <= '0;
      ph_q    <= '0;
      last_q  <= 1'b1;
      vsec_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 2'b00;

      // Shadow of the divider's internal phase counter.
      if (!en_q)        ph_q <= '0;
      else if (ph_wrap) ph_q <= '0;
      else              ph_q <= ph_q + 1'b1;

      unique case (state_q)
        StOff: begin
          if (any_req) begin
            set_q   <= win_div;
            last_q  <= win;
            state_q <= StLoad;
          end else if (run_req) begin
            en_q    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
`ifdef CLK_DIV_CTRL_SKIP_SAME_EN
          if (any_req && (win_div == div_cur)) begin
            set_q     <= win_div;
            last_q    <= win;
            ack_q[win] <= 1'b1;
          end else if (any_req || !run_req) begin
            state_q <= StDrain;
          end
`else
          if (any_req || !run_req) state_q <= StDrain;
`endif
        end
        StDrain: begin
          // Stop only on the toggle that lands the output on PARK_LEVEL.
          if (ph_wrap && (div_clk != PARK_LEVEL)) begin
            en_q <= 1'b0;
            if (any_req) begin
              set_q   <= win_div;
              last_q  <= win;
              state_q <= StLoad;
            end else begin
              state_q <= StOff;
            end
          end
        end
        StLoad: begin
          vsec_q  <= 1'b0;
          state_q <= StVerify;
        end
        StVerify: begin
          if ((div_cur == set_q) || vsec_q) begin
            if (div_cur != set_q) err_q <= 1'b1;
            ack_q[last_q] <= 1'b1;
            vsec_q        <= 1'b0;
            en_q          <= run_req;
            state_q       <= run_req ? StRun : StOff;
          end else begin
            vsec_q <= 1'b1;
          end
        end
        default: begin
          en_q    <= 1'b0;
          state_q <= StOff;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign div_clk_en = en_q;
  assign running    = en_q;
  assign div_set    = set_q;
  assign err        = err_q;
  assign busy       = (state_q == StDrain) || (state_q == StLoad) || (state_q == StVerify);

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Bench for clock_div_ctrl with a behavioural clock_divisor attached.
module tb_clock_div_ctrl;

  localparam logic PARK = 1'b0;

  logic       clk_i = 1'b0;
  logic       rst;
  logic       run_req;
  logic [1:0] req;
  logic [3:0] req_div0, req_div1;
  logic [1:0] ack;
  logic       div_clk_en;
  logic [3:0] div_set;
  logic [3:0] div_cur;
  logic       div_clk;
  logic       running, busy, err;

  int n_pass  = 0;
  int n_total = 0;
  bit m_last  = 1'b1;   // reference: index granted most recently
  bit stuck   = 1'b0;   // makes the divider model ignore loads

  always #5 clk_i = ~clk_i;

  clock_div_ctrl #(.DIV_W(4), .PARK_LEVEL(PARK)) dut (
    .clk_i(clk_i), .rst(rst), .run_req(run_req), .req(req),
    .req_div0(req_div0), .req_div1(req_div1), .ack(ack),
    .div_clk_en(div_clk_en), .div_set(div_set), .div_cur(div_cur),
    .div_clk(div_clk), .running(running), .busy(busy), .err(err)
  );

  // clock_divisor model: loads while disabled, toggles every div+1 edges when enabled.
  logic [3:0] dv_cnt;
  always @(posedge clk_i) begin
    if (rst) begin
      dv_cnt <= 4'd0; div_cur <= 4'd0; div_clk <= 1'b0;
    end else if (!div_clk_en) begin
      dv_cnt <= 4'd0;
      if (!stuck) div_cur <= div_set;
    end else if (dv_cnt == div_cur) begin
      dv_cnt <= 4'd0; div_clk <= ~div_clk;
    end else begin
      dv_cnt <= dv_cnt + 4'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle invariants: running mirrors en, no toggle while stopped, stop lands on PARK.
  bit prev_en = 1'b0, prev_clk = 1'b0, prev_rst = 1'b1;
  always @(negedge clk_i) begin
    if (!rst && !prev_rst) begin
      check("running_eq_en", running, div_clk_en);
      if (!prev_en) check("hold_while_stopped", div_clk, prev_clk);
      if (prev_en && !div_clk_en) check("park_level", div_clk, PARK);
    end
    prev_en  = div_clk_en;
    prev_clk = div_clk;
    prev_rst = rst;
  end

  // Cycles until div_clk changes, bounded.
  task automatic measure_toggle(output int k);
    logic c0;
    c0 = div_clk;
    k  = 0;
    while (div_clk === c0 && k < 40) begin
      @(negedge clk_i);
      k++;
      check("no_ack_while_running", ack, 2'b00);
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((running || busy) && c < 100) begin
      @(negedge clk_i);
      c++;
    end
    check("reached_off", {running, busy}, 2'b00);
  endtask

  // One request pattern; the reference predicts ack order and applied divisors.
  task automatic do_req(input logic [1:0] pat, input logic [3:0] d0, input logic [3:0] d1);
    int         exp_q[$];
    int         cyc;
    int         k;
    logic [3:0] dv;
    if (pat == 2'b11) begin
      exp_q.push_back(m_last ? 0 : 1);
      exp_q.push_back(m_last ? 1 : 0);
    end else begin
      exp_q.push_back(pat[1] ? 1 : 0);
      m_last = pat[1];
    end
    dv       = (exp_q[exp_q.size()-1] == 1) ? d1 : d0;
    req_div0 = d0;
    req_div1 = d1;
    req      = pat;
    cyc      = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      if (ack != 2'b00) begin
        check("ack_who", ack, 2'b01 << exp_q[0]);
        check("ack_div_set", div_set, (exp_q[0] == 1) ? d1 : d0);
        check("ack_div_cur", div_cur, (exp_q[0] == 1) ? d1 : d0);
        req = req & ~ack;
        void'(exp_q.pop_front());
      end
    end
    check("all_acks_seen", exp_q.size(), 0);
    req = 2'b00;
    if (running) begin
      measure_toggle(k);
      check("first_toggle_after_restart", k, dv + 1);
      measure_toggle(k);
      check("half_period", k, dv + 1);
    end
    repeat (3) begin
      @(negedge clk_i);
      check("no_extra_ack", ack, 2'b00);
    end
  endtask

  initial begin
    int         k;
    logic [3:0] d;
    logic [1:0] pat;
    rst = 1'b1; run_req = 1'b0; req = 2'b00; req_div0 = 4'd0; req_div1 = 4'd0;
    repeat (3) @(negedge clk_i);
    check("rst_ack", ack, 2'b00);
    check("rst_en", div_clk_en, 1'b0);
    check("rst_div_set", div_set, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_running", running, 1'b0);

    // Start at divisor 0: running next cycle, toggles every cycle.
    rst = 1'b0;
    @(negedge clk_i);
    run_req = 1'b1;
    @(negedge clk_i);
    check("run_after_one", running, 1'b1);
    for (int i = 0; i < 4; i++) begin
      measure_toggle(k);
      check("div0_toggle", k, 1);
    end
    run_req = 1'b0;
    wait_idle();
    check("park_after_drain", div_clk, PARK);

    // OFF request: ack exactly three edges after sampling.
    req = 2'b01; req_div0 = 4'd5;
    @(negedge clk_i);
    check("off_load_busy", busy, 1'b1);
    check("off_ack_t0", ack, 2'b00);
    @(negedge clk_i);
    check("off_ack_t1", ack, 2'b00);
    @(negedge clk_i);
    check("off_ack_t2", ack, 2'b01);
    check("off_div_set", div_set, 4'd5);
    check("off_div_cur", div_cur, 4'd5);
    check("off_stays_off", running, 1'b0);
    req = 2'b00; m_last = 1'b0;
    @(negedge clk_i);
    check("off_ack_once", ack, 2'b00);
    check("off_idle", busy, 1'b0);

    run_req = 1'b1;
    @(negedge clk_i);
    check("run_at_5", running, 1'b1);
    measure_toggle(k);
    check("first_toggle_5", k, 6);
    measure_toggle(k);
    check("half_period_5", k, 6);

    do_req(2'b01, 4'd3, 4'd0);
    do_req(2'b10, 4'd3, 4'd7);
    do_req(2'b11, 4'd2, 4'd4);
    do_req(2'b11, 4'd6, 4'd1);
    do_req(2'b01, 4'd0, 4'd0);
    run_req = 1'b0;
    wait_idle();
    check("park_div0", div_clk, PARK);

    for (int i = 0; i < 16; i++) begin
      run_req = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 6)) @(negedge clk_i);
      pat = 2'($urandom_range(1, 3));
      do_req(pat, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
      check("err_clear", err, 1'b0);
    end

    // Divider ignores the load: err on second verify cycle, ack anyway.
    run_req = 1'b0;
    wait_idle();
    stuck = 1'b1;
    d = div_cur + 4'd1;
    req = 2'b01; req_div0 = d;
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    check("verify2_no_ack", ack, 2'b00);
    check("verify2_no_err", err, 1'b0);
    @(negedge clk_i);
    check("mismatch_ack", ack, 2'b01);
    check("mismatch_err", err, 1'b1);
    req = 2'b00; m_last = 1'b0; stuck = 1'b0;
    repeat (3) @(negedge clk_i);
    check("err_sticky", err, 1'b1);

    // Reset during VERIFY: no ack, everything back to reset values.
    req = 2'b10; req_div1 = 4'd9;
    @(negedge clk_i);
    @(negedge clk_i);
    check("in_verify_busy", busy, 1'b1);
    rst = 1'b1; req = 2'b00;
    @(negedge clk_i);
    check("rstv_ack", ack, 2'b00);
    check("rstv_en", div_clk_en, 1'b0);
    check("rstv_div_set", div_set, 4'd0);
    check("rstv_busy", busy, 1'b0);
    check("rstv_err", err, 1'b0);
    check("rstv_running", running, 1'b0);
    rst = 1'b0; m_last = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("rstv_no_ack", ack, 2'b00);
      check("rstv_off", {running, busy}, 2'b00);
    end
    do_req(2'b11, 4'd2, 4'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
